// File: rtl/matrix_scan_controller.sv
// Pixel-by-pixel LED matrix scan sequencer: walks (mdc, mdl) over the matrix,
// drives px_en for DWELL clocks per pixel with BLANK dead clocks before each line.
module matrix_scan_controller #(
    parameter int COLS  = 5,
    parameter int ROWS  = 7,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] mdc,
    output logic [2:0] mdl,
    output logic       px_en,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
    localparam logic [2:0] COL_LAST   = 3'(COLS - 1);
    localparam logic [2:0] ROW_LAST   = 3'(ROWS - 1);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [2:0] col_reg, col_next;
    logic [2:0] row_reg, row_next;
    logic       px_en_reg, px_en_next;
    logic       frame_done_reg, frame_done_next;
    logic       busy_reg, busy_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            col_reg        <= '0;
            row_reg        <= '0;
            px_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            px_en_reg      <= px_en_next;
            frame_done_reg <= frame_done_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        col_next   = col_reg;
        row_next   = row_reg;

        case (state_reg)
            S_IDLE: begin
                if (en) begin
                    state_next = S_BLANK;
                    cnt_next   = '0;
                    col_next   = '0;
                    row_next   = '0;
                end
            end
            S_BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = S_DRIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_DRIVE: begin
                if (cnt_reg == DWELL_LAST) begin
                    cnt_next = '0;
                    if (col_reg != COL_LAST) begin
                        col_next = col_reg + 3'd1;
                    end else if (row_reg != ROW_LAST) begin
                        row_next   = row_reg + 3'd1;
                        col_next   = '0;
                        state_next = S_BLANK;
                    end else begin
                        // Frame end is the only point where en is re-examined.
                        row_next   = '0;
                        col_next   = '0;
                        state_next = en ? S_BLANK : S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                col_next   = '0;
                row_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it after the edge.
    always_comb begin
        px_en_next      = (state_next == S_DRIVE);
        busy_next       = (state_next != S_IDLE);
        frame_done_next = (state_next == S_DRIVE) && (cnt_next == DWELL_LAST) &&
                          (col_next == COL_LAST) && (row_next == ROW_LAST);
    end

    assign mdc        = col_reg;
    assign mdl        = row_reg;
    assign px_en      = px_en_reg;
    assign frame_done = frame_done_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: default and corner-parameter instances checked
// every cycle against a frame-time reference model, plus directed and random stimulus.
module tb_matrix_scan_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;

    logic [2:0] mdc0, mdl0, mdc1, mdl1;
    logic       px0, fd0, busy0, px1, fd1, busy1;

    int total = 0;
    int bad   = 0;

    // Per-instance parameters for the model: [0] defaults, [1] corner case.
    int pc[2];
    int pr[2];
    int pw[2];
    int pb[2];

    // Model state: active flag and clock index within the current frame.
    bit act[2];
    int t[2];

    int cyc;
    int px_cnt, busy_cnt, fd_cnt;
    int fd_times[$];

    always #5 clk = ~clk;

    matrix_scan_controller #(.COLS(5), .ROWS(7), .DWELL(4), .BLANK(1)) dut0 (
        .clk(clk), .rst(rst), .en(en),
        .mdc(mdc0), .mdl(mdl0), .px_en(px0), .frame_done(fd0), .busy(busy0)
    );

    matrix_scan_controller #(.COLS(8), .ROWS(8), .DWELL(1), .BLANK(2)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .mdc(mdc1), .mdl(mdl1), .px_en(px1), .frame_done(fd1), .busy(busy1)
    );

    function automatic int frame_len(input int i);
        return pr[i] * (pb[i] + pc[i] * pw[i]);
    endfunction

    // Expected {mdc, mdl, px_en, frame_done, busy} from position in the frame.
    function automatic logic [8:0] expect_out(input int i);
        int line_len, line, w, col;
        logic px;
        if (!act[i]) return 9'd0;
        line_len = pb[i] + pc[i] * pw[i];
        line = t[i] / line_len;
        w    = t[i] % line_len;
        if (w < pb[i]) begin
            px  = 1'b0;
            col = 0;
        end else begin
            px  = 1'b1;
            col = (w - pb[i]) / pw[i];
        end
        return {3'(col), 3'(line), px, (t[i] == frame_len(i) - 1), 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                act[i] = 1'b0;
                t[i]   = 0;
            end else if (!act[i]) begin
                if (e) begin
                    act[i] = 1'b1;
                    t[i]   = 0;
                end
            end else if (t[i] == frame_len(i) - 1) begin
                if (e) t[i] = 0;
                else   act[i] = 1'b0;
            end else begin
                t[i]++;
            end
        end
        @(negedge clk);
        cyc++;
        chk("dflt", {mdc0, mdl0, px0, fd0, busy0}, expect_out(0));
        chk("corner", {mdc1, mdl1, px1, fd1, busy1}, expect_out(1));
        if (px0)   px_cnt++;
        if (busy0) busy_cnt++;
        if (fd0) begin
            fd_cnt++;
            fd_times.push_back(cyc);
        end
    endtask

    task automatic clear_stats();
        px_cnt   = 0;
        busy_cnt = 0;
        fd_cnt   = 0;
        fd_times.delete();
    endtask

    initial begin
        pc = '{5, 8};
        pr = '{7, 8};
        pw = '{4, 1};
        pb = '{1, 2};
        act = '{1'b0, 1'b0};
        t   = '{0, 0};
        cyc = 0;
        clear_stats();

        // Reset with en held high: outputs stay at reset values.
        repeat (3) step(1'b1, 1'b1);

        // Single frame from a one-clock en pulse.
        clear_stats();
        step(1'b0, 1'b1);
        repeat (180) step(1'b0, 1'b0);
        chk_int("single_busy_cycles", busy_cnt, 147);
        chk_int("single_px_cycles", px_cnt, 140);
        chk_int("single_frame_done_count", fd_cnt, 1);

        // Continuous scanning: frame_done spacing equals frame length.
        clear_stats();
        repeat (500) step(1'b0, 1'b1);
        chk_int("cont_frame_done_count", fd_cnt, 3);
        for (int k = 1; k < fd_times.size(); k++)
            chk_int("cont_frame_spacing", fd_times[k] - fd_times[k-1], 147);
        repeat (200) step(1'b0, 1'b0);

        // Stop mid-frame: the frame still completes in full.
        clear_stats();
        repeat (60) step(1'b0, 1'b1);
        repeat (150) step(1'b0, 1'b0);
        chk_int("stop_busy_cycles", busy_cnt, 147);
        chk_int("stop_frame_done_count", fd_cnt, 1);

        // Reset mid-drive, then restart with en held high.
        clear_stats();
        repeat (30) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        clear_stats();
        repeat (147) step(1'b0, 1'b1);
        repeat (200) step(1'b0, 1'b0);
        chk_int("restart_px_cycles", px_cnt, 140);
        chk_int("restart_frame_done_count", fd_cnt, 1);

        // Random en and occasional reset.
        for (int k = 0; k < 2000; k++)
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
        repeat (200) step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
